// File: rtl/rob_wb_tracker_if.sv
// Writeback lanes from the execute units into the ROB completion tracker.
// One slot per lane; the tracker consumes it through the 'in' modport.
interface robWbIf #(
    parameter int unsigned ROB_ADDR_WIDTH       = 4,
    parameter int unsigned DISPATCH_WIDTH       = 2,
    parameter int unsigned DISPATCH_ADDR_WIDTH  = 1,
    parameter int unsigned PHYS_REGS_ADDR_WIDTH = 7
);
    logic [DISPATCH_WIDTH-1:0]                           en;
    logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       rob_addr;
    logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [DISPATCH_WIDTH-1:0]                           is_branch_instr;
    logic [DISPATCH_WIDTH-1:0]                           taken;

    modport in  (input  en, rob_addr, bank_addr, phys_rd, is_branch_instr, taken);
    modport out (output en, rob_addr, bank_addr, phys_rd, is_branch_instr, taken);
endinterface

// File: rtl/rob_wb_tracker.sv
// ROB completion tracker: row allocation, per-entry writeback status and in-order commit.
// Optional ROB_WB_ERR_EN adds a sticky wb_err flag for illegal writebacks.
module rob_wb_tracker #(
    parameter int unsigned ROB_ADDR_WIDTH       = 4,
    parameter int unsigned DISPATCH_WIDTH       = 2,
    parameter int unsigned DISPATCH_ADDR_WIDTH  = 1,
    parameter int unsigned PHYS_REGS_ADDR_WIDTH = 7
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            alloc_en,
    input  logic [DISPATCH_WIDTH-1:0]                       alloc_valid,
    output logic                                            alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0]                       alloc_rob_addr,
    robWbIf.in                                              wb,
    input  logic                                            flush,
    output logic                                            commit_en,
    output logic [ROB_ADDR_WIDTH-1:0]                       commit_rob_addr,
    output logic [DISPATCH_WIDTH-1:0]                       commit_valid,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd,
    output logic [DISPATCH_WIDTH-1:0]                       commit_is_branch,
    output logic [DISPATCH_WIDTH-1:0]                       commit_taken,
    output logic [ROB_ADDR_WIDTH:0]                         count
`ifdef ROB_WB_ERR_EN
    ,
    output logic                                            wb_err
`endif
);
    localparam int unsigned DEPTH = 1 << ROB_ADDR_WIDTH;
    localparam int unsigned CW    = ROB_ADDR_WIDTH + 1;
    localparam int unsigned DW    = DISPATCH_WIDTH;
    localparam int unsigned PW    = PHYS_REGS_ADDR_WIDTH;

    logic [DEPTH-1:0][DW-1:0]         valid_q;
    logic [DEPTH-1:0][DW-1:0]         done_q;
    logic [DEPTH-1:0][DW-1:0]         is_branch_q;
    logic [DEPTH-1:0][DW-1:0]         taken_q;
    logic [DEPTH-1:0][DW-1:0][PW-1:0] phys_rd_q;
    logic [ROB_ADDR_WIDTH-1:0]        head_q;
    logic [ROB_ADDR_WIDTH-1:0]        tail_q;
    logic [CW-1:0]                    count_q;

    logic alloc_fire;
    logic row_done;

    assign alloc_ready    = (count_q < CW'(DEPTH));
    assign alloc_fire     = alloc_en && alloc_ready;
    assign alloc_rob_addr = tail_q;
    assign count          = count_q;

    // Head row is complete when no occupied bank is still waiting for writeback.
    always_comb begin
        row_done = 1'b1;
        for (int unsigned b = 0; b < DW; b++) begin
            if (valid_q[head_q][b] && !done_q[head_q][b]) begin
                row_done = 1'b0;
            end
        end
    end

    assign commit_en        = (count_q != '0) && row_done;
    assign commit_rob_addr  = head_q;
    assign commit_valid     = valid_q[head_q];
    assign commit_phys_rd   = phys_rd_q[head_q];
    assign commit_is_branch = is_branch_q[head_q];
    assign commit_taken     = taken_q[head_q];

    // Lanes are applied in ascending order so the highest lane's write lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            done_q      <= '0;
            is_branch_q <= '0;
            taken_q     <= '0;
            phys_rd_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned l = 0; l < DW; l++) begin
                if (wb.en[l] && valid_q[wb.rob_addr[l]][wb.bank_addr[l]]) begin
                    done_q[wb.rob_addr[l]][wb.bank_addr[l]]      <= 1'b1;
                    phys_rd_q[wb.rob_addr[l]][wb.bank_addr[l]]   <= wb.phys_rd[l];
                    is_branch_q[wb.rob_addr[l]][wb.bank_addr[l]] <= wb.is_branch_instr[l];
                    taken_q[wb.rob_addr[l]][wb.bank_addr[l]]     <= wb.taken[l];
                end
            end
            if (commit_en) begin
                valid_q[head_q] <= '0;
                head_q          <= head_q + ROB_ADDR_WIDTH'(1);
            end
            if (alloc_fire) begin
                valid_q[tail_q] <= alloc_valid;
                done_q[tail_q]  <= '0;
                tail_q          <= tail_q + ROB_ADDR_WIDTH'(1);
            end
            case ({alloc_fire, commit_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ROB_WB_ERR_EN
    logic wb_err_c;

    // Illegal: target not occupied, target already done, or two lanes on one entry.
    always_comb begin
        wb_err_c = 1'b0;
        for (int unsigned l = 0; l < DW; l++) begin
            if (wb.en[l] && (!valid_q[wb.rob_addr[l]][wb.bank_addr[l]]
                             || done_q[wb.rob_addr[l]][wb.bank_addr[l]])) begin
                wb_err_c = 1'b1;
            end
            for (int unsigned k = l + 1; k < DW; k++) begin
                if (wb.en[l] && wb.en[k] && (wb.rob_addr[l] == wb.rob_addr[k])
                    && (wb.bank_addr[l] == wb.bank_addr[k])) begin
                    wb_err_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err <= 1'b0;
        end else if (flush) begin
            wb_err <= 1'b0;
        end else if (wb_err_c) begin
            wb_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_wb_tracker.sv
// Directed bench for rob_wb_tracker: fill/wrap, completion, ordering, full+commit, flush, reset.
// Checks wb_err as well when built with ROB_WB_ERR_EN.
module tb_rob_wb_tracker;
    localparam int unsigned RAW = 4;
    localparam int unsigned DW  = 2;
    localparam int unsigned DAW = 1;
    localparam int unsigned PW  = 7;

    logic                       clk;
    logic                       rst_n;
    logic                       alloc_en;
    logic [DW-1:0]              alloc_valid;
    logic                       alloc_ready;
    logic [RAW-1:0]             alloc_rob_addr;
    logic                       flush;
    logic                       commit_en;
    logic [RAW-1:0]             commit_rob_addr;
    logic [DW-1:0]              commit_valid;
    logic [DW-1:0][PW-1:0]      commit_phys_rd;
    logic [DW-1:0]              commit_is_branch;
    logic [DW-1:0]              commit_taken;
    logic [RAW:0]               count;
`ifdef ROB_WB_ERR_EN
    logic                       wb_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    robWbIf #(
        .ROB_ADDR_WIDTH(RAW), .DISPATCH_WIDTH(DW),
        .DISPATCH_ADDR_WIDTH(DAW), .PHYS_REGS_ADDR_WIDTH(PW)
    ) wb_if ();

    rob_wb_tracker #(
        .ROB_ADDR_WIDTH(RAW), .DISPATCH_WIDTH(DW),
        .DISPATCH_ADDR_WIDTH(DAW), .PHYS_REGS_ADDR_WIDTH(PW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_en         (alloc_en),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_rob_addr   (alloc_rob_addr),
        .wb               (wb_if),
        .flush            (flush),
        .commit_en        (commit_en),
        .commit_rob_addr  (commit_rob_addr),
        .commit_valid     (commit_valid),
        .commit_phys_rd   (commit_phys_rd),
        .commit_is_branch (commit_is_branch),
        .commit_taken     (commit_taken),
        .count            (count)
`ifdef ROB_WB_ERR_EN
        ,
        .wb_err           (wb_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic exp);
`ifdef ROB_WB_ERR_EN
        chk(tag, 64'(wb_err), 64'(exp));
`else
        if (exp === 1'bx) $display("%s", tag);
`endif
    endtask

    // Advance one full cycle; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wb_clr();
        wb_if.en              = '0;
        wb_if.rob_addr        = '0;
        wb_if.bank_addr       = '0;
        wb_if.phys_rd         = '0;
        wb_if.is_branch_instr = '0;
        wb_if.taken           = '0;
    endtask

    task automatic wb_set(input int lane, input logic [RAW-1:0] row, input logic bank,
                          input logic [PW-1:0] prd, input logic br, input logic tk);
        wb_if.en[lane]              = 1'b1;
        wb_if.rob_addr[lane]        = row;
        wb_if.bank_addr[lane]       = bank;
        wb_if.phys_rd[lane]         = prd;
        wb_if.is_branch_instr[lane] = br;
        wb_if.taken[lane]           = tk;
    endtask

    initial begin
        rst_n       = 1'b0;
        alloc_en    = 1'b0;
        alloc_valid = '0;
        flush       = 1'b0;
        wb_clr();
        @(negedge clk);
        @(negedge clk);

        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_addr", 64'(alloc_rob_addr), 64'd0);
        chk("rst_commit_en", 64'(commit_en), 64'd0);
        chk("rst_commit_addr", 64'(commit_rob_addr), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_commit_prd", 64'(commit_phys_rd), 64'd0);
        chk("rst_commit_br", 64'({commit_is_branch, commit_taken}), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk_err("rst_wb_err", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill all 16 rows; tail wraps back to 0.
        alloc_en    = 1'b1;
        alloc_valid = 2'b11;
        for (int i = 0; i < 16; i++) tick();
        alloc_en = 1'b0;
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_alloc_addr", 64'(alloc_rob_addr), 64'd0);
        chk("full_commit_en", 64'(commit_en), 64'd0);

        // Complete row 0 while full, then try to allocate in its commit cycle.
        wb_set(0, 4'd0, 1'b0, 7'd1, 1'b0, 1'b0);
        wb_set(1, 4'd0, 1'b1, 7'd2, 1'b0, 1'b0);
        tick();
        wb_clr();
        alloc_en    = 1'b1;
        alloc_valid = 2'b01;
        chk("fc_commit_en", 64'(commit_en), 64'd1);
        chk("fc_ready_blocked", 64'(alloc_ready), 64'd0);
        tick();
        chk("fc_count_after", 64'(count), 64'd15);
        chk("fc_ready_after", 64'(alloc_ready), 64'd1);
        chk("fc_alloc_addr", 64'(alloc_rob_addr), 64'd0);
        tick();
        alloc_en = 1'b0;
        chk("fc_count_realloc", 64'(count), 64'd16);
        chk("fc_alloc_addr_next", 64'(alloc_rob_addr), 64'd1);
        chk("fc_head", 64'(commit_rob_addr), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl1_count", 64'(count), 64'd0);

        // Row 0: bank 0 then bank 1 one cycle later; commit one cycle after the last.
        alloc_en    = 1'b1;
        alloc_valid = 2'b11;
        tick();
        alloc_en = 1'b0;
        wb_set(0, 4'd0, 1'b0, 7'd5, 1'b0, 1'b0);
        tick();
        wb_clr();
        chk("wb1_partial", 64'(commit_en), 64'd0);
        wb_set(1, 4'd0, 1'b1, 7'd9, 1'b1, 1'b1);
        chk("wb1_no_bypass", 64'(commit_en), 64'd0);
        tick();
        wb_clr();
        chk("wb1_commit_en", 64'(commit_en), 64'd1);
        chk("wb1_valid", 64'(commit_valid), 64'h3);
        chk("wb1_prd0", 64'(commit_phys_rd[0]), 64'd5);
        chk("wb1_prd1", 64'(commit_phys_rd[1]), 64'd9);
        chk("wb1_is_branch", 64'(commit_is_branch), 64'h2);
        chk("wb1_taken", 64'(commit_taken), 64'h2);
        tick();
        chk("wb1_drained", 64'(count), 64'd0);
        chk("wb1_commit_off", 64'(commit_en), 64'd0);

        // Rows 1 and 2; row 2 completes first but waits for row 1.
        alloc_en = 1'b1;
        tick();
        tick();
        alloc_en = 1'b0;
        wb_set(0, 4'd2, 1'b0, 7'd20, 1'b0, 1'b0);
        wb_set(1, 4'd2, 1'b1, 7'd21, 1'b0, 1'b0);
        tick();
        wb_clr();
        chk("ord_hold", 64'(commit_en), 64'd0);
        chk("ord_count", 64'(count), 64'd2);
        wb_set(0, 4'd1, 1'b0, 7'd10, 1'b0, 1'b0);
        wb_set(1, 4'd1, 1'b1, 7'd11, 1'b0, 1'b0);
        tick();
        wb_clr();
        chk("ord_c1_en", 64'(commit_en), 64'd1);
        chk("ord_c1_addr", 64'(commit_rob_addr), 64'd1);
        tick();
        chk("ord_c2_en", 64'(commit_en), 64'd1);
        chk("ord_c2_addr", 64'(commit_rob_addr), 64'd2);
        chk("ord_c2_prd1", 64'(commit_phys_rd[1]), 64'd21);
        tick();
        chk("ord_empty", 64'({count, commit_en}), 64'd0);

        // Empty row commits on the following cycle with no valid banks.
        alloc_en    = 1'b1;
        alloc_valid = 2'b00;
        tick();
        alloc_en = 1'b0;
        chk("empty_commit_en", 64'(commit_en), 64'd1);
        chk("empty_commit_valid", 64'(commit_valid), 64'd0);
        chk("empty_commit_addr", 64'(commit_rob_addr), 64'd3);
        tick();
        chk("empty_count", 64'(count), 64'd0);

        // Rows 0..2 with bank 0 only; illegal writebacks and a lane collision.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        alloc_en    = 1'b1;
        alloc_valid = 2'b01;
        tick();
        tick();
        tick();
        alloc_en = 1'b0;
        chk_err("err_clear", 1'b0);
        wb_set(0, 4'd7, 1'b0, 7'd33, 1'b0, 1'b0);
        tick();
        wb_clr();
        chk("unalloc_count", 64'(count), 64'd3);
        chk("unalloc_commit_en", 64'(commit_en), 64'd0);
        chk_err("unalloc_wb_err", 1'b1);
        wb_set(0, 4'd2, 1'b0, 7'd3, 1'b0, 1'b0);
        wb_set(1, 4'd2, 1'b0, 7'd4, 1'b1, 1'b0);
        tick();
        wb_clr();
        chk("coll_hold", 64'(commit_en), 64'd0);
        chk_err("coll_wb_err", 1'b1);
        wb_set(0, 4'd0, 1'b0, 7'd40, 1'b0, 1'b0);
        wb_set(1, 4'd1, 1'b0, 7'd41, 1'b0, 1'b0);
        tick();
        wb_clr();
        chk("coll_r0", 64'({commit_en, commit_rob_addr, commit_phys_rd[0]}), {52'd0, 1'b1, 4'd0, 7'd40});
        tick();
        chk("coll_r1", 64'({commit_en, commit_rob_addr, commit_phys_rd[0]}), {52'd0, 1'b1, 4'd1, 7'd41});
        tick();
        chk("coll_r2", 64'({commit_en, commit_rob_addr, commit_phys_rd[0]}), {52'd0, 1'b1, 4'd2, 7'd4});
        chk("coll_r2_valid", 64'(commit_valid), 64'h1);
        chk("coll_r2_branch", 64'(commit_is_branch), 64'h1);
        tick();
        chk("coll_drained", 64'({count, commit_en}), 64'd0);

        // Flush with 5 rows pending plus a writeback and allocation in the same cycle.
        alloc_en    = 1'b1;
        alloc_valid = 2'b11;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        wb_set(0, 4'd3, 1'b0, 7'd50, 1'b0, 1'b0);
        tick();
        flush    = 1'b0;
        alloc_en = 1'b0;
        wb_clr();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_commit_en", 64'(commit_en), 64'd0);
        chk("flush_alloc_addr", 64'(alloc_rob_addr), 64'd0);
        chk("flush_valid", 64'(commit_valid), 64'd0);
        chk_err("flush_wb_err", 1'b0);

        // Asynchronous reset mid-operation returns to empty immediately.
        alloc_en = 1'b1;
        tick();
        tick();
        alloc_en = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_alloc_addr", 64'(alloc_rob_addr), 64'd0);
        chk("arst_commit_en", 64'(commit_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(alloc_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
